// File: rtl/pe_stream_arbiter_if.sv
// Bundle between the PE array, the shared DRAM stream port and pe_stream_arbiter.
// The master side drives requests and DRAM handshakes; the slave side is the arbiter.
interface pe_stream_arbiter_if #(
    parameter int NUM_PE = 4,
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 10
);
    localparam int PE_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    logic [NUM_PE-1:0]        req_valid;
    logic [NUM_PE-1:0]        req_filter;
    logic [NUM_PE*ADDR_W-1:0] req_addr;
    logic [NUM_PE*LEN_W-1:0]  req_len;
    logic [NUM_PE-1:0]        gnt;
    logic                     dram_req_valid;
    logic                     dram_req_ready;
    logic [ADDR_W-1:0]        dram_req_addr;
    logic [LEN_W-1:0]         dram_req_len;
    logic                     dram_rsp_valid;
    logic [PE_W-1:0]          rsp_pe;
    logic [NUM_PE-1:0]        stream_input_finish;
    logic [NUM_PE-1:0]        stream_filter_finish;
    logic                     busy;

    modport master (
        output req_valid, req_filter, req_addr, req_len,
        output dram_req_ready, dram_rsp_valid,
        input  gnt, dram_req_valid, dram_req_addr, dram_req_len,
        input  rsp_pe, stream_input_finish, stream_filter_finish, busy
    );

    modport slave (
        input  req_valid, req_filter, req_addr, req_len,
        input  dram_req_ready, dram_rsp_valid,
        output gnt, dram_req_valid, dram_req_addr, dram_req_len,
        output rsp_pe, stream_input_finish, stream_filter_finish, busy
    );
endinterface

// File: rtl/pe_stream_arbiter.sv
// Round-robin arbiter granting one PE at a time the shared DRAM burst/stream port.
// Define FILTER_PRIORITY_EN to arbitrate among filter requests first whenever any is pending.
module pe_stream_arbiter #(
    parameter int NUM_PE = 4,
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 10
) (
    input  logic               clk,
    input  logic               rst,
    pe_stream_arbiter_if.slave bus
);
    localparam int PE_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    logic [1:0]        state_q,  state_d;
    logic [PE_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PE_W-1:0]   idx_q,    idx_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [LEN_W-1:0]  len_q,    len_d;
    logic [LEN_W-1:0]  cnt_q,    cnt_d;
    logic              filt_q,   filt_d;

    logic [NUM_PE-1:0] cand;
    logic              any_req;
    logic [PE_W:0]     rr_sum;
    logic [PE_W-1:0]   win;
    logic              grant;
    logic [NUM_PE-1:0] gnt_vec;
    logic [NUM_PE-1:0] fin_vec;
    logic [LEN_W-1:0]  cnt_inc;
    logic [PE_W-1:0]   idx_next;

`ifdef FILTER_PRIORITY_EN
    // Filter requests shadow input requests; inputs compete only when no filter is pending.
    always_comb begin
        cand = bus.req_valid & bus.req_filter;
        if (cand == '0)
            cand = bus.req_valid;
    end
`else
    assign cand = bus.req_valid;
`endif

    assign any_req = |cand;

    // Scan from the far end back toward rr_ptr so the candidate closest to the pointer wins.
    always_comb begin
        win    = '0;
        rr_sum = '0;
        for (int k = NUM_PE - 1; k >= 0; k--) begin
            rr_sum = {1'b0, rr_ptr_q} + (PE_W+1)'(k);
            if (rr_sum >= (PE_W+1)'(NUM_PE))
                rr_sum = rr_sum - (PE_W+1)'(NUM_PE);
            if (cand[rr_sum[PE_W-1:0]])
                win = rr_sum[PE_W-1:0];
        end
    end

    assign grant    = (state_q == S_IDLE) && any_req && !rst;
    assign cnt_inc  = cnt_q + LEN_W'(1);
    assign idx_next = (idx_q == PE_W'(NUM_PE - 1)) ? '0 : idx_q + PE_W'(1);

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        filt_d   = filt_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d = S_ISSUE;
                    idx_d   = win;
                    addr_d  = bus.req_addr[win*ADDR_W +: ADDR_W];
                    len_d   = bus.req_len[win*LEN_W +: LEN_W];
                    filt_d  = bus.req_filter[win];
                    cnt_d   = '0;
                end
            end
            S_ISSUE: begin
                if (len_q == '0)
                    state_d = S_FINISH;
                else if (bus.dram_req_ready)
                    state_d = S_STREAM;
            end
            S_STREAM: begin
                if (bus.dram_rsp_valid) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q)
                        state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d  = S_IDLE;
                rr_ptr_d = idx_next;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            idx_q    <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            filt_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            filt_q   <= filt_d;
        end
    end

    always_comb begin
        gnt_vec = '0;
        if (grant)
            gnt_vec[win] = 1'b1;
    end

    always_comb begin
        fin_vec = '0;
        if (state_q == S_FINISH)
            fin_vec[idx_q] = 1'b1;
    end

    assign bus.gnt                  = gnt_vec;
    assign bus.dram_req_valid       = (state_q == S_ISSUE) && (len_q != '0);
    assign bus.dram_req_addr        = addr_q;
    assign bus.dram_req_len         = len_q;
    assign bus.rsp_pe               = idx_q;
    assign bus.stream_filter_finish = filt_q ? fin_vec : '0;
    assign bus.stream_input_finish  = filt_q ? '0 : fin_vec;
    assign bus.busy                 = (state_q != S_IDLE);

    a_gnt_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(bus.gnt));
    a_fin_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(bus.stream_filter_finish | bus.stream_input_finish));
    a_req_stable: assert property (@(posedge clk) disable iff (rst)
        bus.dram_req_valid && !bus.dram_req_ready |=>
        bus.dram_req_valid && $stable(bus.dram_req_addr) && $stable(bus.dram_req_len));
endmodule

// File: tb/tb_pe_stream_arbiter.sv
// Bench for pe_stream_arbiter: directed scenarios then random request mixes,
// checked against a transaction-level round-robin model.
module tb_pe_stream_arbiter;
    localparam int NUM_PE = 4;
    localparam int ADDR_W = 16;
    localparam int LEN_W  = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pe_stream_arbiter_if #(.NUM_PE(NUM_PE), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    pe_stream_arbiter #(.NUM_PE(NUM_PE), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: pending request table and round-robin pointer.
    bit                pend [NUM_PE];
    bit                filt [NUM_PE];
    logic [ADDR_W-1:0] a_m  [NUM_PE];
    int                l_m  [NUM_PE];
    int                rr_m;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NUM_PE; i++) begin
            bus.req_valid[i]                   = pend[i];
            bus.req_filter[i]                  = filt[i];
            bus.req_addr[i*ADDR_W +: ADDR_W]   = a_m[i];
            bus.req_len[i*LEN_W +: LEN_W]      = LEN_W'(l_m[i]);
        end
    endtask

    function automatic int pick();
        bit use_filt;
        use_filt = 1'b0;
`ifdef FILTER_PRIORITY_EN
        for (int i = 0; i < NUM_PE; i++)
            if (pend[i] && filt[i]) use_filt = 1'b1;
`endif
        for (int k = 0; k < NUM_PE; k++) begin
            int i;
            i = (rr_m + k) % NUM_PE;
            if (pend[i] && (!use_filt || filt[i])) return i;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input bit f, input logic [ADDR_W-1:0] a, input int l);
        pend[i] = 1'b1;
        filt[i] = f;
        a_m[i]  = a;
        l_m[i]  = l;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},   bus.gnt, 0);
        check({tag, "_dval"},  bus.dram_req_valid, 0);
        check({tag, "_daddr"}, bus.dram_req_addr, 0);
        check({tag, "_dlen"},  bus.dram_req_len, 0);
        check({tag, "_rsppe"}, bus.rsp_pe, 0);
        check({tag, "_ifin"},  bus.stream_input_finish, 0);
        check({tag, "_ffin"},  bus.stream_filter_finish, 0);
        check({tag, "_busy"},  bus.busy, 0);
    endtask

    // One complete burst; exp_w >= 0 pins the expected winner, otherwise the model picks it.
    task automatic run_one(input int exp_w, input int rdy_dly, input int max_gap);
        int w;
        int len;
        logic [63:0] fv;
        drive_reqs();
        #1;
        w = (exp_w >= 0) ? exp_w : pick();
        if (w < 0) return;
        len = l_m[w];
        fv  = 64'(1) << w;
        check("idle_busy", bus.busy, 0);
        check("gnt", bus.gnt, fv);
        tick();
        pend[w] = 1'b0;
        drive_reqs();
        #1;
        check("gnt_pulse", bus.gnt, 0);
        check("issue_busy", bus.busy, 1);
        check("rsp_pe", bus.rsp_pe, w);
        check("dram_addr", bus.dram_req_addr, a_m[w]);
        check("dram_len", bus.dram_req_len, len);
        if (len == 0) begin
            check("len0_no_req", bus.dram_req_valid, 0);
            tick();
        end else begin
            for (int c = 0; c < rdy_dly; c++) begin
                bus.dram_rsp_valid = 1'($urandom_range(0, 1));
                #1;
                check("wait_valid", bus.dram_req_valid, 1);
                check("wait_addr", bus.dram_req_addr, a_m[w]);
                check("wait_len", bus.dram_req_len, len);
                tick();
            end
            bus.dram_rsp_valid = 1'b0;
            bus.dram_req_ready = 1'b1;
            #1;
            check("hs_valid", bus.dram_req_valid, 1);
            tick();
            bus.dram_req_ready = 1'b0;
            #1;
            check("req_drop", bus.dram_req_valid, 0);
            for (int b = 0; b < len; b++) begin
                int gap;
                gap = $urandom_range(0, max_gap);
                for (int g = 0; g < gap; g++) begin
                    bus.dram_rsp_valid = 1'b0;
                    #1;
                    check("gap_fin", bus.stream_input_finish | bus.stream_filter_finish, 0);
                    tick();
                end
                bus.dram_rsp_valid = 1'b1;
                #1;
                check("beat_fin", bus.stream_input_finish | bus.stream_filter_finish, 0);
                check("beat_rsppe", bus.rsp_pe, w);
                tick();
            end
            bus.dram_rsp_valid = 1'b0;
        end
        #1;
        check("fin_filter", bus.stream_filter_finish, filt[w] ? fv : 64'(0));
        check("fin_input", bus.stream_input_finish, filt[w] ? 64'(0) : fv);
        check("fin_gnt", bus.gnt, 0);
        check("fin_dval", bus.dram_req_valid, 0);
        check("fin_busy", bus.busy, 1);
        rr_m = (w + 1) % NUM_PE;
        tick();
        check("back_idle", bus.busy, 0);
    endtask

    task automatic clear_model();
        for (int i = 0; i < NUM_PE; i++) begin
            pend[i] = 1'b0;
            filt[i] = 1'b0;
            a_m[i]  = '0;
            l_m[i]  = 0;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        check_reset_outputs("rst");
        rst  = 1'b0;
        rr_m = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                = 1'b1;
        bus.dram_req_ready = 1'b0;
        bus.dram_rsp_valid = 1'b0;
        clear_model();
        drive_reqs();
        repeat (3) tick();
        check_reset_outputs("por");
        // A request during reset must not be granted.
        set_req(1, 1'b0, 16'h1234, 2);
        drive_reqs();
        #1;
        check("rst_gnt_gated", bus.gnt, 0);
        clear_model();
        drive_reqs();
        rst  = 1'b0;
        rr_m = 0;
        tick();
        check("idle_noreq_gnt", bus.gnt, 0);
        tick();
        check("idle_noreq_busy", bus.busy, 0);

        // Four input requests of length 1: strict rotation, PE0 re-requests and is served last.
        for (int i = 0; i < NUM_PE; i++) set_req(i, 1'b0, ADDR_W'(16'h100 + i), 1);
        run_one(0, 0, 0);
        set_req(0, 1'b0, 16'h0200, 1);
        run_one(1, 0, 0);
        run_one(2, 1, 0);
        run_one(3, 0, 0);
        run_one(0, 0, 0);

        // Filter vs input with pointer at 0.
        apply_reset();
        set_req(0, 1'b0, 16'h0300, 1);
        set_req(3, 1'b1, 16'h0330, 2);
`ifdef FILTER_PRIORITY_EN
        run_one(3, 0, 0);
`else
        run_one(0, 0, 0);
`endif
        run_one(-1, 0, 1);

        // PE1 filter burst of 3 beats at 0x40.
        apply_reset();
        set_req(1, 1'b1, 16'h0040, 3);
        run_one(1, 0, 0);

        // Zero-length request from PE2.
        set_req(2, 1'b0, 16'h0777, 0);
        run_one(2, 0, 0);

        // DRAM not ready for 5 cycles.
        set_req(3, 1'b0, 16'hBEEF, 2);
        run_one(3, 5, 0);

        // Abort mid-stream: PE0 burst leaves pointer at 1, then PE1 is reset after 2 of 4 beats.
        set_req(0, 1'b0, 16'h0010, 1);
        run_one(0, 0, 0);
        set_req(1, 1'b1, 16'h0500, 4);
        drive_reqs();
        #1;
        check("abort_gnt", bus.gnt, 64'h2);
        tick();
        pend[1] = 1'b0;
        drive_reqs();
        bus.dram_req_ready = 1'b1;
        tick();
        bus.dram_req_ready = 1'b0;
        bus.dram_rsp_valid = 1'b1;
        tick();
        tick();
        bus.dram_rsp_valid = 1'b0;
        rst = 1'b1;
        tick();
        check_reset_outputs("abort");
        rst  = 1'b0;
        rr_m = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("abort_nofin", bus.stream_input_finish | bus.stream_filter_finish, 0);
            tick();
        end
        set_req(0, 1'b0, 16'h0600, 1);
        set_req(2, 1'b0, 16'h0620, 1);
        run_one(0, 0, 0);
        run_one(-1, 0, 0);

        // Random request mixes, including requests withdrawn before grant.
        for (int it = 0; it < 80; it++) begin
            bit any;
            any = 1'b0;
            for (int i = 0; i < NUM_PE; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1)
                    set_req(i, 1'($urandom_range(0, 1)), ADDR_W'($urandom),
                            ($urandom_range(0, 9) == 0) ? $urandom_range(8, 12) : $urandom_range(0, 5));
                else if (pend[i] && $urandom_range(0, 7) == 0)
                    pend[i] = 1'b0;
                any |= pend[i];
            end
            if (!any)
                set_req($urandom_range(0, NUM_PE - 1), 1'($urandom_range(0, 1)),
                        ADDR_W'($urandom), $urandom_range(0, 4));
            run_one(-1, $urandom_range(0, 3), 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
